// File: rtl/dcf77_pkg.sv
// Shared constants, frame type and frame-content check for the DCF77 Wishbone slave.
package dcf77_pkg;

    localparam logic [11:0] T0_MIN  = 12'd40;
    localparam logic [11:0] T1_MIN  = 12'd140;
    localparam logic [11:0] T_MAX   = 12'd250;
    localparam logic [11:0] T_MARK  = 12'd1500;
    localparam logic [11:0] T_LOST  = 12'd2500;
    localparam logic [11:0] CNT_SAT = 12'd4095;

    localparam logic [5:0] FRAME_LEN = 6'd59;
    localparam logic [3:0] NENTRY    = 4'd9;

    localparam int unsigned ST_VALID = 7;
    localparam int unsigned ST_ERR   = 6;
    localparam int unsigned ST_NOSIG = 5;

    typedef logic [58:0] dcf_frame_t;

    // Fixed marker bits plus even parity over minutes, hours and date fields
    function automatic logic frame_fields_ok(input dcf_frame_t f);
        return (f[0] == 1'b0) && (f[20] == 1'b1) &&
               ((^f[28:21]) == 1'b0) && ((^f[35:29]) == 1'b0) && ((^f[58:36]) == 1'b0);
    endfunction

endpackage

// File: rtl/if_wishbone.sv
// Minimal Wishbone bundle shared between the bus master and this slave.
interface if_wishbone;
    import dcf77_pkg::*;

    logic [1:0] addr;
    logic [7:0] data_m;
    logic [7:0] data_s;
    logic       we;
    logic       cyc;
    logic       stb;
    logic       ack;

    modport master (output addr, data_m, we, cyc, stb, input data_s, ack);
    modport slave  (input addr, data_m, we, cyc, stb, output data_s, ack);

endinterface

// File: rtl/dcf77_pulse_classifier.sv
// Synchronizes the receiver output, measures high/low widths in ms and
// turns edges into single-cycle bit, marker and pulse-error strobes.
module dcf77_pulse_classifier
    import dcf77_pkg::*;
#(
    parameter int unsigned CLK_HZ = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dcf,
    output logic o_bit_stb,
    output logic o_bit_val,
    output logic o_mark_stb,
    output logic o_perr_stb,
    output logic o_nosig
);

    localparam int unsigned PRESC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [1:0]    r_sync;
    logic          r_prev;
    logic [PW-1:0] r_presc;
    logic [11:0]   r_cnt_hi;
    logic [11:0]   r_cnt_lo;
    logic          r_nosig;
    logic          r_bit_stb, r_bit_val, r_mark_stb, r_perr_stb;

    logic w_high, w_rise, w_fall, w_tick;
    logic w_bit_stb, w_bit_val, w_perr;

    assign w_high = r_sync[1];
    assign w_rise = w_high & ~r_prev;
    assign w_fall = ~w_high & r_prev;
    assign w_tick = (r_presc == PW'(PRESC - 1));

    // Two-flop synchronizer plus edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_dcf};
            r_prev <= r_sync[1];
        end
    end

    // 1 ms prescaler
    always_ff @(posedge clk) begin
        if (rst || w_tick) r_presc <= '0;
        else               r_presc <= r_presc + PW'(1);
    end

    // Saturating width counters, restarted on the edge that opens each phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_hi <= 12'd0;
            r_cnt_lo <= 12'd0;
        end else begin
            if (w_rise)                                         r_cnt_hi <= 12'd0;
            else if (w_high && w_tick && r_cnt_hi != CNT_SAT)   r_cnt_hi <= r_cnt_hi + 12'd1;
            if (w_fall)                                         r_cnt_lo <= 12'd0;
            else if (!w_high && w_tick && r_cnt_lo != CNT_SAT)  r_cnt_lo <= r_cnt_lo + 12'd1;
        end
    end

    // Counters still hold the previous phase on the edge cycle, hence the edge exclusions
    always_comb begin
        w_bit_stb = 1'b0;
        w_bit_val = 1'b0;
        w_perr    = 1'b0;
        if (w_fall && (r_cnt_hi < T_MAX)) begin
            if (r_cnt_hi < T0_MIN) begin
                w_perr = 1'b1;
            end else if (r_cnt_hi < T1_MIN) begin
                w_bit_stb = 1'b1;
            end else begin
                w_bit_stb = 1'b1;
                w_bit_val = 1'b1;
            end
        end else if (w_high && !w_rise && w_tick && (r_cnt_hi == T_MAX - 12'd1)) begin
            w_perr = 1'b1;
        end else begin
            w_perr = 1'b0;
        end
    end

    // Registered strobes and the loss-of-signal level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_stb  <= 1'b0;
            r_bit_val  <= 1'b0;
            r_mark_stb <= 1'b0;
            r_perr_stb <= 1'b0;
            r_nosig    <= 1'b0;
        end else begin
            r_bit_stb  <= w_bit_stb;
            r_bit_val  <= w_bit_val;
            r_mark_stb <= w_rise && (r_cnt_lo >= T_MARK);
            r_perr_stb <= w_perr;
            if (w_rise)                                     r_nosig <= 1'b0;
            else if (!w_high && !w_fall && r_cnt_lo >= T_LOST) r_nosig <= 1'b1;
        end
    end

    assign o_bit_stb  = r_bit_stb;
    assign o_bit_val  = r_bit_val;
    assign o_mark_stb = r_mark_stb;
    assign o_perr_stb = r_perr_stb;
    assign o_nosig    = r_nosig;

endmodule

// File: rtl/wb_dcf77_slave.sv
// Wishbone slave assembling DCF77 minute frames and serving status plus an
// 8-byte shadow copy of the last good frame through a single auto-incrementing address.
module wb_dcf77_slave
    import dcf77_pkg::*;
#(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter logic [1:0]  ADDR   = 2'h1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcf_in,
    if_wishbone.slave  wb
);

    logic w_bit_stb, w_bit_val, w_mark_stb, w_perr_stb, w_nosig;

    dcf77_pulse_classifier #(.CLK_HZ(CLK_HZ)) u_cls (
        .clk        (clk),
        .rst        (rst),
        .i_dcf      (dcf_in),
        .o_bit_stb  (w_bit_stb),
        .o_bit_val  (w_bit_val),
        .o_mark_stb (w_mark_stb),
        .o_perr_stb (w_perr_stb),
        .o_nosig    (w_nosig)
    );

    dcf_frame_t r_frame, r_hold, r_shadow;
    logic [5:0] r_bitcnt;
    logic       r_ovf, r_perr, r_armed;
    logic       r_valid, r_err, r_ack;
    logic [7:0] r_data;
    logic [3:0] r_rdptr;

    logic        w_good, w_frame_ok, w_frame_bad;
    logic        w_req, w_rd, w_wr;
    logic [7:0]  w_status, w_rdata;
    logic [63:0] w_shadow64;
    logic [2:0]  w_idx;
    logic        w_unused;

    assign w_good      = (r_bitcnt == FRAME_LEN) && !r_ovf && !r_perr && frame_fields_ok(r_frame);
    assign w_frame_ok  = w_mark_stb && r_armed && w_good;
    assign w_frame_bad = w_mark_stb && r_armed && !w_good;

    // The first marker after reset only aligns the decoder; no frame is judged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame  <= '0;
            r_hold   <= '0;
            r_bitcnt <= 6'd0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_armed  <= 1'b0;
        end else if (w_mark_stb) begin
            if (w_frame_ok) r_hold <= r_frame;
            r_bitcnt <= 6'd0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
            r_armed  <= 1'b1;
        end else begin
            if (w_bit_stb && r_armed) begin
                if (r_bitcnt == FRAME_LEN) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_frame[r_bitcnt] <= w_bit_val;
                    r_bitcnt          <= r_bitcnt + 6'd1;
                end
            end
            if (w_perr_stb) r_perr <= 1'b1;
        end
    end

    assign w_req      = wb.cyc && wb.stb && (wb.addr == ADDR) && !r_ack;
    assign w_rd       = w_req && !wb.we;
    assign w_wr       = w_req && wb.we;
    assign w_shadow64 = {5'b00000, r_shadow};
    assign w_idx      = 3'(r_rdptr - 4'd1);
    assign w_unused   = ^{wb.data_m[7], wb.data_m[5:0]};

    // Read mux: entry 0 is status, entries 1..8 walk the shadow LSB first
    always_comb begin
        w_status           = 8'h00;
        w_status[ST_VALID] = r_valid;
        w_status[ST_ERR]   = r_err;
        w_status[ST_NOSIG] = w_nosig;
        if (r_rdptr == 4'd0) w_rdata = w_status;
        else                 w_rdata = w_shadow64[{w_idx, 3'b000} +: 8];
    end

    // Bus response, read pointer and tear-free shadow snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_data   <= 8'h00;
            r_rdptr  <= 4'd0;
            r_shadow <= '0;
        end else begin
            r_ack  <= w_req;
            r_data <= w_rd ? w_rdata : 8'h00;
            if (w_rd) begin
                r_rdptr <= (r_rdptr == NENTRY - 4'd1) ? 4'd0 : r_rdptr + 4'd1;
                if (r_rdptr == 4'd0) r_shadow <= r_hold;
            end else if (w_wr) begin
                r_rdptr <= 4'd0;
            end
        end
    end

    // Frame outcome flags; a same-cycle set beats a bus clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_frame_ok)                          r_valid <= 1'b1;
            else if (w_rd && r_rdptr == 4'd0)        r_valid <= 1'b0;
            if (w_frame_bad)                         r_err <= 1'b1;
            else if (w_wr && wb.data_m[ST_ERR])      r_err <= 1'b0;
        end
    end

    assign wb.ack    = r_ack;
    assign wb.data_s = r_data;

endmodule

// File: tb/tb_wb_dcf77_slave.sv
// Directed bench for wb_dcf77_slave; CLK_HZ=1000 makes one millisecond one clock.
module tb_wb_dcf77_slave;

    localparam int unsigned CLK_HZ = 1000;
    localparam logic [1:0]  ADDR   = 2'h1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dcf_in = 1'b0;

    if_wishbone wb();

    wb_dcf77_slave #(.CLK_HZ(CLK_HZ), .ADDR(ADDR)) dut (
        .clk    (clk),
        .rst    (rst),
        .dcf_in (dcf_in),
        .wb     (wb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] frame_v;
    logic [7:0]  exp_bytes [1:8];

    task automatic idle_bus();
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.addr = 2'h0; wb.data_m = 8'h00;
    endtask

    task automatic pulse(input int high_ms, input int low_ms);
        @(posedge clk); #1 dcf_in = 1'b1;
        repeat (high_ms) @(posedge clk);
        #1 dcf_in = 1'b0;
        repeat (low_ms) @(posedge clk);
    endtask

    // Long low gap then a 50 ms pulse, which also becomes bit 0 of the next frame
    task automatic marker();
        repeat (1600) @(posedge clk);
        pulse(50, 40);
    endtask

    task automatic bus_read(output logic [7:0] d, output logic a1, output logic a2);
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = ADDR;
        @(posedge clk); #1;
        idle_bus();
        a1 = wb.ack; d = wb.data_s;
        @(posedge clk); #1;
        a2 = wb.ack;
    endtask

    task automatic bus_write(input logic [7:0] v, output logic a1);
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.addr = ADDR; wb.data_m = v;
        @(posedge clk); #1;
        idle_bus();
        a1 = wb.ack;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic a1, a2;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (wb.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb.ack); end
        n_checks++; if (wb.data_s !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", wb.data_s); end
        rst = 1'b0;
        bus_read(d, a1, a2);
        n_checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin n_fail++; $display("FAIL reset_ack_pulse: got %b%b want 10", a1, a2); end
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", d); end
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_byte1: got %h want 00", d); end
        n_checks++; if (dut.r_rdptr !== 4'd2) begin n_fail++; $display("FAIL reset_rdptr: got %0d want 2", dut.r_rdptr); end
    endtask

    task automatic test_good_frame();
        logic [7:0] d; logic a1, a2;
        marker();
        for (int i = 1; i < 59; i++) pulse(frame_v[i] ? 150 : 50, 40);
        marker();
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL good_status: got %h want 80", d); end
        for (int k = 1; k <= 8; k++) begin
            bus_read(d, a1, a2);
            n_checks++; if (d !== exp_bytes[k]) begin n_fail++; $display("FAIL good_byte%0d: got %h want %h", k, d, exp_bytes[k]); end
        end
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL good_status_reread: got %h want 00", d); end
    endtask

    task automatic test_back_to_back();
        logic a1;
        logic       acks [0:3];
        logic [7:0] dats [0:3];
        bus_write(8'h00, a1);
        n_checks++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL b2b_write_ack: got %b want 1", a1); end
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = ADDR;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            acks[j] = wb.ack; dats[j] = wb.data_s;
        end
        idle_bus();
        n_checks++; if ({acks[0], acks[1], acks[2], acks[3]} !== 4'b1010) begin
            n_fail++; $display("FAIL b2b_ack_pattern: got %b%b%b%b want 1010", acks[0], acks[1], acks[2], acks[3]); end
        n_checks++; if (dats[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_status: got %h want 00", dats[0]); end
        n_checks++; if (dats[1] !== 8'h00) begin n_fail++; $display("FAIL b2b_idle_data: got %h want 00", dats[1]); end
        n_checks++; if (dats[2] !== 8'h08) begin n_fail++; $display("FAIL b2b_byte1: got %h want 08", dats[2]); end
    endtask

    task automatic test_pulse_error();
        logic [7:0] d; logic a1, a2;
        for (int i = 1; i < 59; i++) pulse((i == 10) ? 300 : (frame_v[i] ? 150 : 50), 40);
        marker();
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h40) begin n_fail++; $display("FAIL perr_status: got %h want 40", d); end
        bus_write(8'h40, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL perr_cleared: got %h want 00", d); end
    endtask

    task automatic test_bad_count();
        logic [7:0] d; logic a1, a2;
        for (int i = 0; i < 57; i++) pulse(50, 40);
        marker();
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h40) begin n_fail++; $display("FAIL short_frame: got %h want 40", d); end
        bus_write(8'h40, a1);
        for (int i = 0; i < 59; i++) pulse(50, 40);
        marker();
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h40) begin n_fail++; $display("FAIL long_frame: got %h want 40", d); end
        bus_write(8'h40, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL long_cleared: got %h want 00", d); end
    endtask

    task automatic test_nosig();
        logic [7:0] d; logic a1, a2;
        repeat (2600) @(posedge clk);
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h20) begin n_fail++; $display("FAIL nosig_set: got %h want 20", d); end
        @(posedge clk); #1 dcf_in = 1'b1;
        repeat (10) @(posedge clk);
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h40) begin n_fail++; $display("FAIL nosig_cleared: got %h want 40", d); end
        repeat (30) @(posedge clk);
        #1 dcf_in = 1'b0;
        repeat (40) @(posedge clk);
        bus_write(8'h40, a1);
    endtask

    task automatic test_addr_filter();
        logic [7:0] d; logic a1, a2; logic seen;
        bus_write(8'h00, a1);
        bus_read(d, a1, a2);
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = 2'h2;
        seen = 1'b0;
        for (int j = 0; j < 3; j++) begin @(posedge clk); #1; seen = seen | wb.ack; end
        wb.we = 1'b1; wb.addr = 2'h3; wb.data_m = 8'h40;
        for (int j = 0; j < 3; j++) begin @(posedge clk); #1; seen = seen | wb.ack; end
        idle_bus();
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL addr_no_ack: got %b want 0", seen); end
        n_checks++; if (dut.r_rdptr !== 4'd1) begin n_fail++; $display("FAIL addr_rdptr: got %0d want 1", dut.r_rdptr); end
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h08) begin n_fail++; $display("FAIL addr_byte1: got %h want 08", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d; logic a1, a2;
        bus_write(8'h00, a1);
        for (int j = 0; j < 4; j++) bus_read(d, a1, a2);
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = ADDR;
        rst = 1'b1;
        @(posedge clk); #1;
        idle_bus();
        n_checks++; if (wb.ack !== 1'b0) begin n_fail++; $display("FAIL rst_read_ack: got %b want 0", wb.ack); end
        @(posedge clk); #1 rst = 1'b0;
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_status: got %h want 00", d); end
        n_checks++; if (dut.r_rdptr !== 4'd1) begin n_fail++; $display("FAIL rst_rdptr: got %0d want 1", dut.r_rdptr); end
        bus_read(d, a1, a2);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_shadow: got %h want 00", d); end
    endtask

    initial begin
        frame_v   = 64'h0498_ED52_5692_0208;
        exp_bytes = '{8'h08, 8'h02, 8'h92, 8'h56, 8'h52, 8'hED, 8'h98, 8'h04};
        idle_bus();
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_pulse_error();
        test_bad_count();
        test_nosig();
        test_addr_filter();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
